// File: rtl/hdmi_qsys_input_capture_if.sv
// Avalon-MM slave bus bundle for the HDMI_QSYS input-capture PIO.
interface hdmi_qsys_input_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/hdmi_qsys_input_capture.sv
// Input PIO: synchronizes an async word, exposes it on DATA, captures
// per-bit edges into a sticky W1C register and drives a maskable level irq.
// Optional debounce stage selected by defining INPUT_DEBOUNCE_EN.
module hdmi_qsys_input_capture #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  hdmi_qsys_input_capture_if.slave bus,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Reject configurations the register map cannot represent.
  if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
    $error("hdmi_qsys_input_capture: DATA_WIDTH must be 1..32");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("hdmi_qsys_input_capture: DEBOUNCE_CYCLES must be >= 1");
  end
  if (EDGE_TYPE > 2) begin : g_bad_edge
    $error("hdmi_qsys_input_capture: EDGE_TYPE must be 0, 1 or 2");
  end

  logic [DATA_WIDTH-1:0] sync1;
  logic [DATA_WIDTH-1:0] sync2;
  logic [DATA_WIDTH-1:0] filtered;
  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_capture;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] w1c_clr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wr_en;

  assign wr_en = bus.chipselect & ~bus.write_n;
  assign wdata = bus.writedata[DATA_WIDTH-1:0];

  // Two-flop synchronizer for the asynchronous input word.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef INPUT_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [DATA_WIDTH-1:0] cand;
  logic [CNT_W-1:0]      cnt;

  // Word-wide debounce: sync2 must hold one value for the whole window.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand     <= '0;
      cnt      <= '0;
      filtered <= '0;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= '0;
    end else if (cand != filtered) begin
      if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filtered <= cand;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end
`else
  assign filtered = sync2;
`endif

  // Previous filtered word for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
    end else begin
      prev <= filtered;
    end
  end

  // Per-bit edge selection and W1C clear vector.
  always_comb begin
    edge_det = '0;
    w1c_clr  = '0;
    if (EDGE_TYPE == 0) begin
      edge_det = filtered & ~prev;
    end else if (EDGE_TYPE == 1) begin
      edge_det = ~filtered & prev;
    end else begin
      edge_det = filtered ^ prev;
    end
    if (wr_en && bus.address == ADDR_EDGE) begin
      w1c_clr = wdata;
    end
  end

  // Mask register and sticky edge capture; a new edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && bus.address == ADDR_MASK) begin
        irq_mask <= wdata;
      end
      edge_capture <= (edge_capture & ~w1c_clr) | edge_det;
    end
  end

  assign irq = |(edge_capture & irq_mask);

  // Zero-wait-state read mux; unused upper bits and reserved address read 0.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA: bus.readdata = 32'(filtered);
      ADDR_MASK: bus.readdata = 32'(irq_mask);
      ADDR_EDGE: bus.readdata = 32'(edge_capture);
      default:   bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hdmi_qsys_input_capture.sv
// Directed bench: one DUT per EDGE_TYPE sharing clk, reset and in_port.
module tb_hdmi_qsys_input_capture;

`ifdef INPUT_DEBOUNCE_EN
  localparam int EXTRA = 5;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LVL = 4 + 2 * EXTRA;

  logic        clk;
  logic        reset;
  logic [31:0] in_port;
  logic        irq0, irq1, irq2;
  logic [31:0] d;
  int          checks;
  int          failures;

  hdmi_qsys_input_capture_if bus0 ();
  hdmi_qsys_input_capture_if bus1 ();
  hdmi_qsys_input_capture_if bus2 ();

  hdmi_qsys_input_capture #(.DATA_WIDTH(32), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4)) u0 (
    .clk(clk), .reset(reset), .bus(bus0), .in_port(in_port), .irq(irq0));
  hdmi_qsys_input_capture #(.DATA_WIDTH(32), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(4)) u1 (
    .clk(clk), .reset(reset), .bus(bus1), .in_port(in_port), .irq(irq1));
  hdmi_qsys_input_capture #(.DATA_WIDTH(32), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(4)) u2 (
    .clk(clk), .reset(reset), .bus(bus2), .in_port(in_port), .irq(irq2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_bus(input logic [1:0] a, input logic cs, input logic wn,
                         input logic [31:0] wd);
    bus0.address = a; bus0.chipselect = cs; bus0.write_n = wn; bus0.writedata = wd;
    bus1.address = a; bus1.chipselect = cs; bus1.write_n = wn; bus1.writedata = wd;
    bus2.address = a; bus2.chipselect = cs; bus2.write_n = wn; bus2.writedata = wd;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    set_bus(a, 1'b1, 1'b0, wd);
    ticks(1);
    set_bus(2'd0, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic rd(input int inst, input logic [1:0] a, output logic [31:0] v);
    set_bus(a, 1'b1, 1'b1, 32'd0);
    #1;
    case (inst)
      0:       v = bus0.readdata;
      1:       v = bus1.readdata;
      default: v = bus2.readdata;
    endcase
    set_bus(2'd0, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    set_bus(2'd0, 1'b0, 1'b1, 32'd0);
    in_port = 32'd0;
    reset = 1'b1;
    ticks(3);
    reset = 1'b0;

    // Reset state
    rd(0, 2'd0, d); chk("reset_data", d, 32'h0);
    rd(0, 2'd1, d); chk("reset_rsvd", d, 32'h0);
    rd(0, 2'd2, d); chk("reset_mask", d, 32'h0);
    rd(0, 2'd3, d); chk("reset_edge", d, 32'h0);
    chk("reset_irq", {29'd0, irq2, irq1, irq0}, 32'h0);

    wr(2'd1, 32'hFFFF_FFFF);
    rd(0, 2'd1, d); chk("rsvd_write_ignored", d, 32'h0);
    wr(2'd0, 32'hFFFF_FFFF);
    rd(0, 2'd0, d); chk("data_write_ignored", d, 32'h0);

    // Rising capture with mask
    wr(2'd2, 32'h5);
    rd(0, 2'd2, d); chk("mask_readback", d, 32'h5);
    in_port = 32'h7;
    ticks(1 + EXTRA);
    rd(0, 2'd0, d); chk("data_before_E1", d, 32'h0);
    ticks(1);
    rd(0, 2'd0, d); chk("data_after_E1", d, 32'h7);
    rd(0, 2'd3, d); chk("edge_before_E2", d, 32'h0);
    chk("irq_before_E2", {31'd0, irq0}, 32'h0);
    ticks(1);
    rd(0, 2'd3, d); chk("edge_rise_E2", d, 32'h7);
    chk("irq_rise_E2", {31'd0, irq0}, 32'h1);
    rd(1, 2'd3, d); chk("edge_fall_inst_on_rise", d, 32'h0);
    rd(2, 2'd3, d); chk("edge_any_inst_on_rise", d, 32'h7);

    // W1C racing a new edge on bit 0
    in_port = 32'h6;
    ticks(4 + EXTRA);
    wr(2'd3, 32'h1);
    rd(0, 2'd3, d); chk("w1c_bit0", d, 32'h6);
    in_port = 32'h7;
    ticks(2 + EXTRA);
    wr(2'd3, 32'h1);
    rd(0, 2'd3, d); chk("set_beats_w1c", d, 32'h7);
    chk("irq_pending", {31'd0, irq0}, 32'h1);
    wr(2'd3, 32'h5);
    rd(0, 2'd3, d); chk("w1c_0x5", d, 32'h2);
    chk("irq_after_w1c", {31'd0, irq0}, 32'h0);

    // Falling (u1) and any (u2) on bit 3
    ticks(4);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(1, 2'd3, d); chk("fall_cleared", d, 32'h0);
    rd(2, 2'd3, d); chk("any_cleared", d, 32'h0);
    in_port = 32'hF;
    ticks(LVL);
    rd(1, 2'd3, d); chk("fall_after_rise", d, 32'h0);
    rd(2, 2'd3, d); chk("any_after_rise", d, 32'h8);
    in_port = 32'h7;
    ticks(LVL);
    rd(1, 2'd3, d); chk("fall_after_fall", d, 32'h8);
    rd(2, 2'd3, d); chk("any_after_fall", d, 32'h8);
    chk("fall_irq_masked", {31'd0, irq1}, 32'h0);

    // Mid-operation reset
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd2, 32'h3);
    in_port = 32'h4;
    ticks(4 + EXTRA);
    wr(2'd3, 32'hFFFF_FFFF);
    in_port = 32'h7;
    ticks(3 + EXTRA);
    rd(0, 2'd3, d); chk("pre_reset_edge", d, 32'h3);
    chk("pre_reset_irq", {31'd0, irq0}, 32'h1);
    reset = 1'b1;
    ticks(1);
    rd(0, 2'd0, d); chk("midrst_data", d, 32'h0);
    rd(0, 2'd2, d); chk("midrst_mask", d, 32'h0);
    rd(0, 2'd3, d); chk("midrst_edge", d, 32'h0);
    chk("midrst_irq", {31'd0, irq0}, 32'h0);
    reset = 1'b0;

    // High input at reset release is captured but does not interrupt
    ticks(3 + EXTRA);
    rd(0, 2'd0, d); chk("release_data", d, 32'h7);
    rd(0, 2'd3, d); chk("release_edge", d, 32'h7);
    chk("release_irq", {31'd0, irq0}, 32'h0);

`ifdef INPUT_DEBOUNCE_EN
    // Debounce: short glitch rejected, steady level accepted
    wr(2'd3, 32'hFFFF_FFFF);
    in_port = 32'hF;
    ticks(2);
    in_port = 32'h7;
    ticks(12);
    rd(0, 2'd0, d); chk("glitch_data", d, 32'h7);
    rd(0, 2'd3, d); chk("glitch_edge", d, 32'h0);
    in_port = 32'hF;
    ticks(6);
    rd(0, 2'd0, d); chk("deb_data_E5", d, 32'h7);
    ticks(1);
    rd(0, 2'd0, d); chk("deb_data_E6", d, 32'hF);
    rd(0, 2'd3, d); chk("deb_edge_E6", d, 32'h0);
    ticks(1);
    rd(0, 2'd3, d); chk("deb_edge_E7", d, 32'h8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
